// File: rtl/ct_load_ctrl.sv
// Ciphertext loader in front of doublecrack: streams a length-prefixed message into
// the shared ciphertext RAM, starts the crack, reports the key. Optional watchdog: CT_LOAD_CTRL_TIMEOUT_EN.
module ct_load_ctrl #(
  parameter int TIMEOUT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        ct_wren,
  output logic [7:0]  ct_addr,
  output logic [7:0]  ct_wrdata,
  output logic        crack_en,
  input  logic        crack_rdy,
  input  logic        crack_key_valid,
  input  logic [23:0] crack_key,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [23:0] result_key,
  output logic        err_len,
  output logic [2:0]  dbg_state
);

  // Handshake: a byte transfers on any cycle where in_valid && in_ready are both high;
  // in_ready depends only on state, never on in_valid.
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DRAIN, S_WAIT_RDY, S_START, S_WAIT_BUSY, S_WAIT_DONE, S_REPORT
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  count_q, count_d;
  logic [8:0]  count_inc;
  logic [7:0]  len_q, len_d;
  logic        wb_cnt_q, wb_cnt_d;
  logic        found_q, found_d;
  logic [23:0] key_q, key_d;
  logic        err_q, err_d;

`ifdef CT_LOAD_CTRL_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
`else
  logic unused_timeout_w;
  assign unused_timeout_w = (TIMEOUT_W > 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      len_q    <= '0;
      wb_cnt_q <= 1'b0;
      found_q  <= 1'b0;
      key_q    <= '0;
      err_q    <= 1'b0;
`ifdef CT_LOAD_CTRL_TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      len_q    <= len_d;
      wb_cnt_q <= wb_cnt_d;
      found_q  <= found_d;
      key_q    <= key_d;
      err_q    <= err_d;
`ifdef CT_LOAD_CTRL_TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    len_d     = len_q;
    wb_cnt_d  = wb_cnt_q;
    found_d   = found_q;
    key_d     = key_q;
    err_d     = err_q;
`ifdef CT_LOAD_CTRL_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif
    count_inc = count_q + 9'd1;
    in_ready  = 1'b0;
    ct_wren   = 1'b0;
    ct_addr   = 8'd0;
    ct_wrdata = 8'd0;
    crack_en  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy     = 1'b0;
        in_ready = 1'b1;
        if (in_valid) begin
          ct_wren   = 1'b1;
          ct_wrdata = in_data;
          len_d     = in_data;
          count_d   = 9'd1;
          err_d     = 1'b0;
          found_d   = 1'b0;
          key_d     = '0;
          if (in_data == 8'd0) begin
            err_d   = 1'b1;
            state_d = S_REPORT;
          end else if (in_data == 8'd1) begin
            if (in_last) begin
              state_d = S_WAIT_RDY;
            end else begin
              err_d   = 1'b1;
              state_d = S_DRAIN;
            end
          end else if (in_last) begin
            err_d   = 1'b1;
            state_d = S_REPORT;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ct_wren   = 1'b1;
          ct_addr   = count_q[7:0];
          ct_wrdata = in_data;
          count_d   = count_inc;
          if (count_inc == {1'b0, len_q}) begin
            if (in_last) begin
              state_d = S_WAIT_RDY;
            end else begin
              err_d   = 1'b1;
              state_d = S_DRAIN;
            end
          end else if (in_last) begin
            err_d   = 1'b1;
            state_d = S_REPORT;
          end
        end
      end
      S_DRAIN: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_d = S_REPORT;
      end
      S_WAIT_RDY: begin
        if (crack_rdy) state_d = S_START;
      end
      S_START: begin
        crack_en = 1'b1;
        wb_cnt_d = 1'b0;
`ifdef CT_LOAD_CTRL_TIMEOUT_EN
        tmo_d    = '0;
`endif
        state_d  = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        // A crack that finishes before rdy is ever seen low still counts as done.
        if (!crack_rdy || wb_cnt_q) state_d = S_WAIT_DONE;
        else wb_cnt_d = 1'b1;
      end
      S_WAIT_DONE: begin
        if (crack_rdy) begin
          found_d = crack_key_valid;
          key_d   = crack_key_valid ? crack_key : 24'd0;
          state_d = S_REPORT;
        end
      end
      S_REPORT: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef CT_LOAD_CTRL_TIMEOUT_EN
    if (state_q == S_WAIT_BUSY || state_q == S_WAIT_DONE) begin
      if (&tmo_q) begin
        found_d = 1'b0;
        key_d   = '0;
        err_d   = 1'b1;
        state_d = S_REPORT;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif

    // Hold every strobe quiet for the whole reset cycle, not just after it.
    if (rst) begin
      in_ready  = 1'b0;
      ct_wren   = 1'b0;
      ct_addr   = 8'd0;
      ct_wrdata = 8'd0;
      crack_en  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
    end
  end

  assign found      = found_q;
  assign result_key = key_q;
  assign err_len    = err_q;
  assign dbg_state  = state_q;

endmodule
